// File: rtl/key_ctrl_pkg.sv
// Shared types and defaults for the key-load controller.
// KEY_PARITY_EN adds the PARITY state to the FSM encoding.
package key_ctrl_pkg;

   localparam int unsigned KEY_W_DEFAULT = 16;

`ifdef KEY_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      READY  = 2'd2,
      PARITY = 2'd3
   } key_state_e;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      READY  = 2'd2
   } key_state_e;
`endif

endpackage

// File: rtl/key_shift_reg.sv
// LSB-first shadow register with a saturating bit counter.
// KEY_PARITY_EN exposes the even-parity reduction of the shadow.
module key_shift_reg
   import key_ctrl_pkg::*;
#(
   parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             sdi,
   output logic [KEY_W-1:0] shadow,
   output logic             last_c
`ifdef KEY_PARITY_EN
   ,
   output logic             parity_c
`endif
);

   localparam int unsigned CNT_W = $clog2(KEY_W + 1);

   logic [CNT_W-1:0] count;

   // Counter stops at KEY_W so a stray enable can never wrap it.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         shadow <= '0;
         count  <= '0;
      end else if (shift_en && (count != CNT_W'(KEY_W))) begin
         for (int unsigned i = 0; i < KEY_W; i++) begin
            if (count == CNT_W'(i)) begin
               shadow[i] <= sdi;
            end
         end
         count <= count + CNT_W'(1);
      end
   end

   assign last_c = (count == CNT_W'(KEY_W - 1));

`ifdef KEY_PARITY_EN
   assign parity_c = ^shadow;
`endif

endmodule

// File: rtl/key_load_ctrl.sv
// Serial key loader for a logic-locked netlist: shift, (optionally check parity), commit.
// Define KEY_PARITY_EN to require an even-parity bit after the last key bit.
module key_load_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int unsigned     KEY_W     = KEY_W_DEFAULT,
   parameter logic [KEY_W-1:0] RESET_KEY = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sdi,
   input  logic             sdi_valid,
   input  logic             commit,
   input  logic             abort,
   output logic [KEY_W-1:0] key_out,
   output logic             key_applied,
   output logic             busy,
   output logic             err
);

   key_state_e       state;
   logic [KEY_W-1:0] shadow;
   logic             last_c;
   logic             clr;
   logic             shift_en;
`ifdef KEY_PARITY_EN
   logic             parity_c;
`endif

   assign clr      = (state == IDLE) && start;
   assign shift_en = (state == SHIFT) && sdi_valid && !abort;

   key_shift_reg #(
      .KEY_W (KEY_W)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_en),
      .sdi      (sdi),
      .shadow   (shadow),
      .last_c   (last_c)
`ifdef KEY_PARITY_EN
      ,
      .parity_c (parity_c)
`endif
   );

   // busy tracks the next state so it is a clean register equal to state != IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         err         <= 1'b0;
         key_out     <= RESET_KEY;
         key_applied <= 1'b0;
      end else begin
         err <= (start && (state != IDLE)) || (commit && (state != READY));
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (sdi_valid && last_c) begin
`ifdef KEY_PARITY_EN
                  state <= PARITY;
`else
                  state <= READY;
`endif
               end
            end
`ifdef KEY_PARITY_EN
            PARITY: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (sdi_valid) begin
                  if (sdi == parity_c) begin
                     state <= READY;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            READY: begin
               // Abort outranks a simultaneous commit.
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (commit) begin
                  key_out     <= shadow;
                  key_applied <= 1'b1;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_key_load_ctrl;

   localparam int unsigned KW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          sdi = 1'b0;
   logic          sdi_valid = 1'b0;
   logic          commit = 1'b0;
   logic          abort = 1'b0;
   logic [KW-1:0] key_out;
   logic          key_applied;
   logic          busy;
   logic          err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   key_load_ctrl #(
      .KEY_W     (KW),
      .RESET_KEY (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .sdi         (sdi),
      .sdi_valid   (sdi_valid),
      .commit      (commit),
      .abort       (abort),
      .key_out     (key_out),
      .key_applied (key_applied),
      .busy        (busy),
      .err         (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collected bits in a queue, phase as a small integer.
   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_PAR   = 2;
   localparam int M_READY = 3;

   bit            m_valid = 1'b0;
   bit            m_bits[$];
   int            m_mode = M_IDLE;
   logic [KW-1:0] m_key = '0;
   bit            m_applied = 1'b0;
   bit            m_err = 1'b0;

   function automatic logic [KW-1:0] bits_value();
      logic [KW-1:0] v = '0;
      for (int i = 0; i < m_bits.size(); i++) v[i] = m_bits[i];
      return v;
   endfunction

   function automatic bit bits_parity();
      int ones = 0;
      for (int i = 0; i < m_bits.size(); i++) ones += int'(m_bits[i]);
      return bit'(ones % 2);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid   = 1'b1;
         m_mode    = M_IDLE;
         m_bits.delete();
         m_key     = '0;
         m_applied = 1'b0;
         m_err     = 1'b0;
      end else if (m_valid) begin
         m_err = (start && m_mode != M_IDLE) || (commit && m_mode != M_READY);
         case (m_mode)
            M_IDLE: if (start) begin
               m_bits.delete();
               m_mode = M_LOAD;
            end
            M_LOAD: if (abort) m_mode = M_IDLE;
               else if (sdi_valid) begin
                  m_bits.push_back(sdi);
                  if (m_bits.size() == KW) begin
`ifdef KEY_PARITY_EN
                     m_mode = M_PAR;
`else
                     m_mode = M_READY;
`endif
                  end
               end
            M_PAR: if (abort) m_mode = M_IDLE;
               else if (sdi_valid) begin
                  if (sdi == bits_parity()) m_mode = M_READY;
                  else begin
                     m_mode = M_IDLE;
                     m_err  = 1'b1;
                  end
               end
            default: if (abort) m_mode = M_IDLE;
               else if (commit) begin
                  m_key     = bits_value();
                  m_applied = 1'b1;
                  m_mode    = M_IDLE;
               end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("key_out", 32'(key_out), 32'(m_key));
         check("key_applied", 32'(key_applied), 32'(m_applied));
         check("busy", 32'(busy), 32'(m_mode != M_IDLE));
         check("err", 32'(err), 32'(m_err));
      end
   end

   task automatic tick(input bit s, input bit v, input bit d, input bit c, input bit a);
      @(negedge clk);
      start = s; sdi_valid = v; sdi = d; commit = c; abort = a;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; sdi_valid = 1'b0; sdi = 1'b0; commit = 1'b0; abort = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic load_key(input logic [KW-1:0] k, input bit gap);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < KW; i++) begin
         tick(1'b0, 1'b1, k[i], 1'b0, 1'b0);
         if (gap) tick(1'b0, 1'b0, ~k[i], 1'b0, 1'b0);
      end
`ifdef KEY_PARITY_EN
      tick(1'b0, 1'b1, ^k, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      do_reset();
      check("rst key_out", 32'(key_out), 32'h0000);
      check("rst key_applied", 32'(key_applied), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst err", 32'(err), 32'd0);

      load_key(16'hA5C3, 1'b0);
      check("a5c3 ready busy", 32'(busy), 32'd1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("a5c3 key_out", 32'(key_out), 32'hA5C3);
      check("a5c3 applied", 32'(key_applied), 32'd1);
      check("a5c3 busy", 32'(busy), 32'd0);

      load_key(16'h1234, 1'b1);
      check("1234 ready busy", 32'(busy), 32'd1);
      check("1234 held old key", 32'(key_out), 32'hA5C3);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("1234 key_out", 32'(key_out), 32'h1234);

      load_key(16'hFFFF, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("abort key_out", 32'(key_out), 32'hFFFF);
      check("abort busy", 32'(busy), 32'd0);
      check("abort applied", 32'(key_applied), 32'd1);

      load_key(16'h0F0F, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("commit+abort key_out", 32'(key_out), 32'hFFFF);
      check("commit+abort busy", 32'(busy), 32'd0);
      check("commit+abort err", 32'(err), 32'd0);

      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("start busy err", 32'(err), 32'd1);
      check("start busy stays", 32'(busy), 32'd1);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("err one cycle", 32'(err), 32'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("idle commit err", 32'(err), 32'd1);
      check("idle commit busy", 32'(busy), 32'd0);
      check("idle commit key", 32'(key_out), 32'hFFFF);

`ifdef KEY_PARITY_EN
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < KW; i++) tick(1'b0, 1'b1, (i == 0), 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bad parity err", 32'(err), 32'd1);
      check("bad parity busy", 32'(busy), 32'd0);
      check("bad parity key", 32'(key_out), 32'hFFFF);
      load_key(16'h0001, 1'b0);
      check("good parity busy", 32'(busy), 32'd1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("good parity key", 32'(key_out), 32'h0001);
`endif

      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      check("midload rst key", 32'(key_out), 32'h0000);
      check("midload rst applied", 32'(key_applied), 32'd0);
      check("midload rst busy", 32'(busy), 32'd0);

      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 19) == 0);
         sdi_valid = ($urandom_range(0, 9) < 6);
         sdi       = 1'($urandom);
         commit    = ($urandom_range(0, 4) == 0);
         abort     = ($urandom_range(0, 39) == 0);
      end

      @(negedge clk);
      rst = 1'b0; start = 1'b0; sdi_valid = 1'b0; commit = 1'b0; abort = 1'b0;
      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
